// File: rtl/mem_rsp_pkg.sv
// Shared types for the data-memory responder: FSM encoding, request latch layout
// and word/counter widths.
package mem_rsp_pkg;
    localparam int WORD_W    = 32;
    localparam int WAIT_W    = 4;
    localparam int NUM_LANES = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                 write;
        logic [WORD_W-1:0]    addr;
        logic [WORD_W-1:0]    wdata;
        logic [NUM_LANES-1:0] be;
    } mem_req_t;
endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: synchronous byte-lane writes, registered read.
// Each byte lane is an independent 8-bit array so lane enables map to separate write ports.
module dmem_array
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic                 re,
    input  logic [NUM_LANES-1:0] be,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0] mem [0:DEPTH_WORDS-1];
        logic [7:0] rd_q;

        always_ff @(posedge clock) begin
            if (we && be[l]) mem[addr] <= wdata[8*l +: 8];
            if (re)          rd_q      <= mem[addr];
        end

        assign rdata[8*l +: 8] = rd_q;
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: one request at a time, WAIT_CYCLES of access latency,
// response held until the core takes it.
module data_mem_responder
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt;
    mem_req_t          req_q;
    logic              addr_err, access, ram_we, ram_re;
    logic [WORD_W-1:0] ram_q;

    assign addr_err = (req_q.addr[1:0] != 2'b00) ||
                      (req_q.addr[WORD_W-1:2] >= (WORD_W-2)'(DEPTH_WORDS));
    assign access   = (state == WAIT) && (cnt == '0);
    // Gate with reset so a store caught by reset on its RAM edge is dropped too.
    assign ram_we   = access && reset && req_q.write && !addr_err;
    assign ram_re   = access && !req_q.write && !addr_err;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= '0;
            rsp_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_valid && req_ready) begin
                req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
                cnt   <= WAIT_W'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access)                      rsp_err <= addr_err;
            else if (rsp_valid && rsp_ready) rsp_err <= 1'b0;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    // RAM read register only updates on the access edge, so data stays stable through RESP.
    assign rsp_rdata = (rsp_valid && !req_q.write && !rsp_err) ? ram_q : '0;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .be    (req_q.be),
        .addr  (req_q.addr[AW+1:2]),
        .wdata (req_q.wdata),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a transaction-level model predicts every
// handshake and response; directed cases pin the model with literal values.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_reset, b_req_valid, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int pass_cnt = 0, total_cnt = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    // Transaction-level model: memory image plus the one outstanding request.
    bit [31:0]   mmem [DEPTH];
    int          ecnt = 0, acc_edge = 0;
    bit          busy = 0;
    logic        m_w;
    logic [31:0] m_a, m_d, m_rdata;
    logic [3:0]  m_be;
    logic        m_err;

    always @(posedge clock) begin
        ecnt++;
        if (!reset) begin
            busy = 0;
        end else if (!busy) begin
            if (req_valid) begin
                busy = 1; acc_edge = ecnt;
                m_w = req_write; m_a = req_addr; m_d = req_wdata; m_be = req_be;
            end
        end else if (ecnt == acc_edge + W + 1) begin
            m_err   = (m_a[1:0] != 0) || (m_a[31:2] >= DEPTH);
            m_rdata = 0;
            if (!m_err && m_w) begin
                for (int i = 0; i < 4; i++)
                    if (m_be[i]) mmem[m_a[31:2]][8*i +: 8] = m_d[8*i +: 8];
            end else if (!m_err) begin
                m_rdata = mmem[m_a[31:2]];
            end
        end else if (ecnt > acc_edge + W + 1 && rsp_ready) begin
            busy = 0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_valid;
            exp_valid = busy && (ecnt >= acc_edge + W + 1);
            chk("cmp_req_ready", {31'd0, req_ready}, {31'd0, !busy});
            chk("cmp_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("cmp_rdata", rsp_rdata, m_rdata);
                chk("cmp_err", {31'd0, rsp_err}, {31'd0, m_err});
            end
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold, input bit rnd,
                       output logic [31:0] rd, output logic er, output int lat);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clock); #1;
        req_valid = 0;
        req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (rnd) rsp_ready = 1'($urandom);
            @(posedge clock); #1; lat++;
        end
        rsp_ready = 0;
        if (lat >= 40) chk("rsp_timeout", 32'(lat), 32'd0);
        rd = rsp_rdata; er = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1;
        @(posedge clock); #1;
        rsp_ready = 0;
        chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic store_reset(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1; req_write = 1; req_addr = a; req_wdata = d; req_be = 4'hF;
        @(posedge clock); #1;
        req_valid = 0;
        @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;
        reset = 1;
        for (int k = 0; k < 6; k++) begin
            chk("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
            @(posedge clock); #1;
        end
    endtask

    task automatic run_b();
        logic        bw [16];
        logic [31:0] ba [16], bd [16];
        int i = 0, j = 0, cyc = 0, last = 0;
        for (int k = 0; k < 16; k++) begin
            bw[k] = (k < 8);
            ba[k] = 32'((k % 8) * 4 + 32'h40);
            bd[k] = (k < 8) ? $urandom : 32'h0;
        end
        while (j < 16 && cyc < 200) begin
            if (b_rsp_valid) begin
                chk("b2b_rdata", b_rsp_rdata, bw[j] ? 32'h0 : bd[j-8]);
                chk("b2b_err", {31'd0, b_rsp_err}, 32'd0);
                if (j > 0) chk("b2b_period", 32'(cyc - last), 32'd3);
                last = cyc; j++;
            end
            if (b_req_ready) begin
                if (i < 16) begin
                    b_req_valid = 1; b_req_write = bw[i]; b_req_addr = ba[i];
                    b_req_wdata = bd[i]; b_req_be = 4'hF; i++;
                end else b_req_valid = 0;
            end
            @(posedge clock); #1; cyc++;
        end
        chk("b2b_count", 32'(j), 32'd16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a;
        logic        er;
        int          lat;
        reset = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        rsp_ready = 0;
        b_reset = 0; b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_b_req_ready", {31'd0, b_req_ready}, 32'd1);
        reset = 1; b_reset = 1; chk_en = 1;

        for (int k = 0; k < DEPTH; k++) txn(1, 32'(k * 4), $urandom, 4'hF, 0, 0, rd, er, lat);

        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
        chk("t1_st_lat", 32'(lat), 32'd3);
        chk("t1_st_rdata", rd, 32'h0);
        chk("t1_st_err", {31'd0, er}, 32'd0);
        txn(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        chk("t1_ld_lat", 32'(lat), 32'd3);
        chk("t1_ld_rdata", rd, 32'hDEADBEEF);
        chk("t1_ld_err", {31'd0, er}, 32'd0);

        txn(1, 32'h20, 32'hAABBCCDD, 4'hF, 0, 0, rd, er, lat);
        txn(1, 32'h20, 32'h11223344, 4'b0101, 0, 0, rd, er, lat);
        txn(0, 32'h20, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("t2_partial", rd, 32'hAA22CC44);

        txn(1, 32'h4, 32'h55667788, 4'hF, 0, 0, rd, er, lat);
        txn(0, 32'h6, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("t3_mis_err", {31'd0, er}, 32'd1);
        chk("t3_mis_rdata", rd, 32'h0);
        txn(0, 32'(4 * DEPTH), 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("t3_rng_err", {31'd0, er}, 32'd1);
        chk("t3_rng_rdata", rd, 32'h0);
        txn(1, 32'h6, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat);
        chk("t3_st_err", {31'd0, er}, 32'd1);
        txn(0, 32'h4, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("t3_word4", rd, 32'h55667788);

        txn(0, 32'h10, 32'h0, 4'h0, 5, 0, rd, er, lat);
        chk("t4_rdata", rd, 32'hDEADBEEF);

        txn(1, 32'h30, 32'h0BADF00D, 4'hF, 0, 0, rd, er, lat);
        store_reset(32'h30, 32'h12345678);
        txn(0, 32'h30, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("t5_old_value", rd, 32'h0BADF00D);

        txn(1, 32'h10, 32'h01010101, 4'h0, 0, 0, rd, er, lat);
        txn(0, 32'h10, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk("be0_noop", rd, 32'hDEADBEEF);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
                2:       a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
                default: a = ($urandom_range(0, 1) != 0) ? 32'(4 * DEPTH + 4 * $urandom_range(0, 64))
                                                         : ($urandom | 32'h8000_0000);
            endcase
            txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 1, rd, er, lat);
        end

        run_b();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
